seg_scan: RTL

//  Four-digit multiplexed scanner that sits directly upstream of the 7-segment

---
 rtl/seg_scan.sv | 109 ++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed scanner for a 7-segment display.
// It captures a 16-bit hex value and its decimal-point flags into shadow registers.
// It presents one nibble at a time on x3..x0, which feed the segment decoder.
// It drives the matching active-low digit anode.
// Each slot starts with a few anti-ghost cycles in which every anode is off.
// Leading-zero digits can be blanked, and each digit has its own decimal point.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (release expected synchronous to clk)
//   load       in   capture value/dp_in into the shadow registers
//   value      in   [15:12] digit 3 ... [3:0] digit 0
//   dp_in      in   decimal point request per digit, 1 = lit
//   en         in   0 forces all anodes off; scanning continues
//   x0..x3     out  selected nibble, x0 = LSB
//   an         out  digit anodes, active-low, an[k] drives digit k
//   dp         out  decimal point, active-low
//   digit_sel  out  current digit index
module seg_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2,
  parameter int LZB   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        en,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  digit_sel
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_value;
  logic [3:0]    r_dp;
  // en is registered so outputs depend on registers only.
  logic          r_en;

  logic [3:0]    w_nib;
  logic [3:0]    w_lz_blank;
  logic          w_lit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_value <= 16'h0000;
      r_dp    <= 4'b0000;
      r_en    <= 1'b0;
    end else begin
      r_en <= en;
      if (load) begin
        r_value <= value;
        r_dp    <= dp_in;
      end
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // The nibble is selected even during blank cycles and while disabled.
  // This lets the decoder settle before the anode turns on.
  always_comb begin
    w_nib = r_value[3:0];
    unique case (r_idx)
      2'd0: w_nib = r_value[3:0];
      2'd1: w_nib = r_value[7:4];
      2'd2: w_nib = r_value[11:8];
      2'd3: w_nib = r_value[15:12];
      default: w_nib = r_value[3:0];
    endcase
  end

  // A digit is blanked only when it and every digit above it are zero.
  // Digit 0 always shows, so a value of zero displays a single "0".
  always_comb begin
    w_lz_blank    = 4'b0000;
    w_lz_blank[3] = (LZB != 0) && (r_value[15:12] == 4'h0);
    w_lz_blank[2] = w_lz_blank[3] && (r_value[11:8] == 4'h0);
    w_lz_blank[1] = w_lz_blank[2] && (r_value[7:4] == 4'h0);
  end

  always_comb begin
    w_lit = r_en && (int'(r_cnt) >= BLANK) && !w_lz_blank[r_idx];
    an    = w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
    dp    = w_lit ? ~r_dp[r_idx] : 1'b1;
  end

  assign x0        = w_nib[0];
  assign x1        = w_nib[1];
  assign x2        = w_nib[2];
  assign x3        = w_nib[3];
  assign digit_sel = r_idx;

endmodule
